// File: rtl/audio_i2s_tx.sv
// Philips I2S transmitter: 16-bit stereo in 32-bit slots, clk/4 SCLK, clk/256 LRCK.
// One-deep pending buffer with valid/ready intake; frames underrun to silence when empty.
module audio_i2s_tx (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] sample_l,
    input  logic [15:0] sample_r,
    input  logic        sample_valid,
    output logic        sample_ready,
    input  logic        mute,
    output logic        i2s_sclk,
    output logic        i2s_lrck,
    output logic        i2s_data,
    output logic        frame_start,
    output logic        underrun
);

    logic [1:0]  div_q, div_d;
    logic [5:0]  bitcnt_q, bitcnt_d;
    logic [15:0] pend_l_q, pend_l_d;
    logic [15:0] pend_r_q, pend_r_d;
    logic        pend_full_q, pend_full_d;
    logic [15:0] act_l_q, act_l_d;
    logic [15:0] act_r_q, act_r_d;
    logic        lrck_q, lrck_d;
    logic        data_q, data_d;
    logic        fs_q, fs_d;
    logic        und_q, und_d;

    logic        bit_edge;
    logic        boundary;
    logic        xfer;
    logic [4:0]  pos;
    logic [3:0]  idx;
    logic [15:0] word;

    always_comb begin
        div_d       = div_q + 2'd1;
        bit_edge    = (div_q == 2'd3);
        boundary    = bit_edge && (bitcnt_q == 6'd63);
        xfer        = sample_valid && !pend_full_q;
        bitcnt_d    = bit_edge ? bitcnt_q + 6'd1 : bitcnt_q;
        pend_l_d    = pend_l_q;
        pend_r_d    = pend_r_q;
        pend_full_d = pend_full_q;
        act_l_d     = act_l_q;
        act_r_d     = act_r_q;
        fs_d        = boundary;
        und_d       = boundary && !pend_full_q;

        if (boundary) begin
            if (pend_full_q && !mute) begin
                act_l_d = pend_l_q;
                act_r_d = pend_r_q;
            end else begin
                act_l_d = '0;
                act_r_d = '0;
            end
            pend_full_d = 1'b0;
        end

        // Intake only happens while empty, so it never races a consume.
        if (xfer) begin
            pend_l_d    = sample_l;
            pend_r_d    = sample_r;
            pend_full_d = 1'b1;
        end

        // Slot p=1..16 carries bit 16-p, i.e. index ~(p-1) in 4 bits.
        pos    = bitcnt_d[4:0];
        idx    = ~(pos[3:0] - 4'd1);
        word   = bitcnt_d[5] ? act_r_d : act_l_d;
        lrck_d = lrck_q;
        data_d = data_q;
        if (bit_edge) begin
            lrck_d = bitcnt_d[5];
            data_d = (pos != 5'd0) && (pos <= 5'd16) && word[idx];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q       <= 2'd0;
            bitcnt_q    <= 6'd63;
            pend_l_q    <= '0;
            pend_r_q    <= '0;
            pend_full_q <= 1'b0;
            act_l_q     <= '0;
            act_r_q     <= '0;
            lrck_q      <= 1'b0;
            data_q      <= 1'b0;
            fs_q        <= 1'b0;
            und_q       <= 1'b0;
        end else begin
            div_q       <= div_d;
            bitcnt_q    <= bitcnt_d;
            pend_l_q    <= pend_l_d;
            pend_r_q    <= pend_r_d;
            pend_full_q <= pend_full_d;
            act_l_q     <= act_l_d;
            act_r_q     <= act_r_d;
            lrck_q      <= lrck_d;
            data_q      <= data_d;
            fs_q        <= fs_d;
            und_q       <= und_d;
        end
    end

    assign sample_ready = ~pend_full_q;
    assign i2s_sclk     = div_q[1];
    assign i2s_lrck     = lrck_q;
    assign i2s_data     = data_q;
    assign frame_start  = fs_q;
    assign underrun     = und_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Scoreboard bench for audio_i2s_tx: a frame-level model queues expected frames,
// a negedge monitor pops on each frame_start and checks every clk of output.
module tb_audio_i2s_tx;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic        und;
    } frm_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] sample_l = '0;
    logic [15:0] sample_r = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic        mute = 1'b0;
    logic        i2s_sclk;
    logic        i2s_lrck;
    logic        i2s_data;
    logic        frame_start;
    logic        underrun;

    int          n_pass = 0;
    int          n_total = 0;

    // Reference model state: n = clk edges since reset release.
    int          n = 0;
    bit          mfull = 1'b0;
    logic [15:0] pl = '0;
    logic [15:0] pr = '0;
    int          acc_cnt = 0;
    frm_t        expq[$];

    frm_t        cur;
    bit          have_cur = 1'b0;

    audio_i2s_tx dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .mute         (mute),
        .i2s_sclk     (i2s_sclk),
        .i2s_lrck     (i2s_lrck),
        .i2s_data     (i2s_data),
        .frame_start  (frame_start),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t n=%0d)",
                      name, act, exp, $time, n);
    endtask

    // Model: frame k starts at edge 4+256k; a pending pair plays in the
    // frame whose boundary follows its acceptance.
    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                n = 0;
                mfull = 1'b0;
                expq.delete();
            end else begin
                bit bnd;
                bit xf;
                n++;
                bnd = (n >= 4) && ((n - 4) % 256 == 0);
                xf  = sample_valid && !mfull;
                if (bnd) begin
                    if (mfull) begin
                        if (mute) expq.push_back('{16'h0, 16'h0, 1'b0});
                        else      expq.push_back('{pl, pr, 1'b0});
                    end else begin
                        expq.push_back('{16'h0, 16'h0, 1'b1});
                    end
                    mfull = 1'b0;
                end
                if (xf) begin
                    pl = sample_l;
                    pr = sample_r;
                    mfull = 1'b1;
                    acc_cnt++;
                end
            end
        end
    end

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                have_cur = 1'b0;
                chk("rst_sclk", i2s_sclk, 0);
                chk("rst_lrck", i2s_lrck, 0);
                chk("rst_data", i2s_data, 0);
                chk("rst_fs", frame_start, 0);
                chk("rst_und", underrun, 0);
                chk("rst_ready", sample_ready, 1);
            end else begin
                int  bc;
                int  p;
                bit  efs;
                bit  ed;
                logic [15:0] w;
                efs = (n >= 4) && ((n - 4) % 256 == 0);
                bc  = (n >= 4) ? ((n / 4 - 1) % 64) : -1;
                chk("sclk", i2s_sclk, 32'((n % 4) >= 2));
                chk("lrck", i2s_lrck, 32'(bc >= 32));
                chk("frame_start", frame_start, 32'(efs));
                chk("ready", sample_ready, 32'(!mfull));
                if (frame_start) begin
                    chk("exp_avail", 32'(expq.size() > 0), 1);
                    if (expq.size() > 0) begin
                        cur = expq.pop_front();
                        have_cur = 1'b1;
                        chk("underrun", underrun, 32'(cur.und));
                    end
                end else begin
                    chk("underrun_idle", underrun, 0);
                end
                ed = 1'b0;
                if (bc >= 0 && have_cur) begin
                    p = bc % 32;
                    w = (bc >= 32) ? cur.r : cur.l;
                    if (p >= 1 && p <= 16) ed = w[16 - p];
                end
                chk("data", i2s_data, 32'(ed));
            end
        end
    end

    task automatic send(input logic [15:0] l, input logic [15:0] r);
        int c0;
        int k;
        c0 = acc_cnt;
        @(negedge clk);
        sample_l = l;
        sample_r = r;
        sample_valid = 1'b1;
        k = 0;
        while (acc_cnt == c0 && k < 1000) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("send_accepted", 32'(acc_cnt != c0), 1);
    endtask

    task automatic idle(input int k);
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (k) @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        int k;
        do_reset();
        idle(20);
        // Frame 0 underruns; this pair plays in frame 1.
        send(16'hA5F0, 16'h0001);
        idle(520);
        // Back-pressure: second pair waits for the next boundary.
        send(16'h1234, 16'h5678);
        send(16'h9ABC, 16'hDEF0);
        idle(800);
        send(16'h0F0F, 16'hF0F0);
        idle(600);
        // Mute with a pending pair.
        send(16'h7FFF, 16'h8000);
        @(negedge clk);
        mute = 1'b1;
        idle(300);
        mute = 1'b0;
        idle(300);
        for (int i = 0; i < 10; i++) begin
            send(16'($urandom), 16'($urandom));
            @(negedge clk);
            mute = ($urandom_range(0, 4) == 0);
            idle($urandom_range(0, 400));
        end
        mute = 1'b0;
        idle(300);
        // Mid-frame reset at bitcnt = 20 with SCLK high and a pending pair.
        send(16'hFFFF, 16'hFFFF);
        send(16'hFFFF, 16'hFFFF);
        k = 0;
        while (!(n >= 4 && ((n / 4 - 1) % 64) == 20 && (n % 4) == 2)
               && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("reach_bc20", 32'(k < 2000), 1);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_sclk", i2s_sclk, 0);
        chk("mid_rst_lrck", i2s_lrck, 0);
        chk("mid_rst_data", i2s_data, 0);
        chk("mid_rst_fs", frame_start, 0);
        chk("mid_rst_und", underrun, 0);
        chk("mid_rst_ready", sample_ready, 1);
        sample_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        idle(20);
        send(16'hC3C3, 16'h3C3C);
        idle(600);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/audio_i2s_tx.md
AUDIO_I2S_TX -- requirements
Module: audio_i2s_tx

Interface
REQ-001 The block SHALL have port `clk`: input, 1 bit; the audio master clock (12.288 MHz), the only clock.
REQ-002 The block SHALL have port `reset_n`: input, 1 bit; asynchronous, active-low reset.
REQ-003 The block SHALL have port `sample_l`: input, 16 bits; left PCM sample, two's complement.
REQ-004 The block SHALL have port `sample_r`: input, 16 bits; right PCM sample, two's complement.
REQ-005 The block SHALL have port `sample_valid`: input, 1 bit; the sample pair is offered.
REQ-006 The block SHALL have port `sample_ready`: output, 1 bit; the pending buffer is empty.
REQ-007 The block SHALL have port `mute`: input, 1 bit; forces silent frames.
REQ-008 The block SHALL have port `i2s_sclk`: output, 1 bit; bit clock, clk/4 (3.072 MHz).
REQ-009 The block SHALL have port `i2s_lrck`: output, 1 bit; word select, 0 = left, 1 = right, clk/256 (48 kHz).
REQ-010 The block SHALL have port `i2s_data`: output, 1 bit; serial data, Philips I2S format.
REQ-011 The block SHALL have port `frame_start`: output, 1 bit; one-clk pulse at each frame boundary.
REQ-012 The block SHALL have port `underrun`: output, 1 bit; one-clk pulse when a frame starts with no pending sample.

Function
REQ-013 Clock divider: a 2-bit counter `div` SHALL increment every clk and wrap from 3 to 0.
REQ-014 `i2s_sclk` SHALL equal div[1], registered, so it is low for div 0-1 and high for div 2-3.
REQ-015 Bit edge: the clk edge on which div goes 3->0 SHALL be the bit edge; `i2s_lrck` and `i2s_data` SHALL change only on bit edges, i.e. on SCLK falling edges.
REQ-016 A 6-bit counter `bitcnt` (0..63) SHALL advance on each bit edge and wrap from 63 to 0.
REQ-017 `i2s_lrck` SHALL equal bitcnt[5].
REQ-018 The slot position SHALL be p = bitcnt[4:0].
REQ-019 For p = 1..16, `i2s_data` SHALL carry bit (16-p) of the active word for the current channel, MSB first.
REQ-020 For p = 0 and p = 17..31, `i2s_data` SHALL be 0.
REQ-021 Frame boundary: the bit edge on which bitcnt wraps 63->0 SHALL be the frame boundary.
REQ-022 On the frame boundary, if the pending buffer is full, the pending pair SHALL move into the active pair and the pending buffer SHALL become empty.
REQ-023 On the frame boundary, if the pending buffer is empty, the active pair SHALL load zero and `underrun` SHALL pulse for that single clk.
REQ-024 `mute` SHALL be sampled only at the frame boundary; when it is 1, the active pair SHALL load zero and the pending pair SHALL still be consumed.
REQ-025 Mute SHALL NOT raise `underrun` if a pending pair existed.
REQ-026 `frame_start` SHALL pulse high for one clk on every frame boundary.
REQ-027 Handshake: `sample_ready` SHALL equal the complement of the registered pending_full flag.
REQ-028 A transfer SHALL occur when sample_valid && sample_ready on a clk edge; the pair is captured into pending and pending_full is set.
REQ-029 While pending is full, `sample_ready` SHALL be 0 and the inputs SHALL be ignored.
REQ-030 Simultaneous events: if a transfer and an empty-buffer frame boundary fall on the same edge, the frame SHALL underrun (zero) and the new pair SHALL land in pending for the next frame.
REQ-031 Latency: for a pair accepted before a boundary, the left MSB SHALL appear on `i2s_data` 4 clk after that boundary (p = 1).
REQ-032 The right MSB SHALL appear 132 clk after that boundary.

Reset
REQ-033 While reset_n = 0, the outputs SHALL be: i2s_sclk 0, i2s_lrck 0, i2s_data 0, frame_start 0, underrun 0.
REQ-034 While reset_n = 0, div SHALL be 0, bitcnt SHALL be 63, the pending and active pairs SHALL be 0, pending_full SHALL be 0, and sample_ready SHALL read 1.
REQ-035 Reset assertion mid-frame SHALL clear all state immediately, independent of clk.
REQ-036 The first frame boundary SHALL occur on the 4th clk edge after reset_n deasserts; with no sample written, that frame SHALL underrun.

Verification
REQ-037 Free-run check: after reset -> i2s_sclk period 4 clk with 50% duty, i2s_lrck period 256 clk, frame_start every 256 clk.
REQ-038 Data check: write L=0xA5F0, R=0x0001 before the 2nd boundary -> left slots p1..16 = 1010010111110000, right slots = 0000000000000001, all other slots 0, no underrun in that frame.
REQ-039 Back-pressure check: hold sample_valid high with two different pairs back-to-back -> the second is accepted only on the clk after the next boundary, and each pair is transmitted exactly once, in order.
REQ-040 Underrun check: stop writing for one frame -> underrun pulses once at that boundary, the frame is all zeros, and the next written pair plays in the following frame.
REQ-041 Mute check: assert mute with a pending pair 0x7FFF/0x8000 -> the frame is all zeros, no underrun, and sample_ready returns to 1 after the boundary.
REQ-042 Reset-mid-frame check: pull reset_n low at bitcnt = 20 -> all outputs are 0 at once; after release, timing restarts per REQ-036.
